// File: rtl/mips_pkg.sv
// Kind codes, opcode/funct constants and register aliases shared by the encoder and decoder.
// Pure definitions: no logic, no timing.
package mips_pkg;

   typedef enum logic [3:0] {
      K_NOP  = 4'd0,
      K_LW   = 4'd1,
      K_SW   = 4'd2,
      K_BEQ  = 4'd3,
      K_BNE  = 4'd4,
      K_XORI = 4'd5,
      K_ADDI = 4'd6,
      K_J    = 4'd7,
      K_JAL  = 4'd8,
      K_ADD  = 4'd9,
      K_SUB  = 4'd10,
      K_SLT  = 4'd11,
      K_JR   = 4'd12,
      K_BLT  = 4'd13,
      K_BGE  = 4'd14,
      K_BAD  = 4'd15
   } kind_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;

   localparam logic [5:0] FN_ADD   = 6'h20;
   localparam logic [5:0] FN_SUB   = 6'h22;
   localparam logic [5:0] FN_SLT   = 6'h2A;
   localparam logic [5:0] FN_JR    = 6'h08;

   localparam logic [4:0] AT_REG   = 5'd1;

   function automatic logic is_pseudo_kind(input logic [3:0] k);
      return (k == K_BLT) || (k == K_BGE);
   endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: one real instruction kind plus its fields in, one 32-bit word out.
// Pseudo and illegal kinds pack to zero; the caller remaps pseudo kinds before packing.
module instr_pack
   import mips_pkg::*;
(
   input  logic [3:0]  kind,
   input  logic [4:0]  rs,
   input  logic [4:0]  rt,
   input  logic [4:0]  rd,
   input  logic [15:0] imm,
   input  logic [25:0] jaddr,
   output logic [31:0] word
);

   kind_e k;
   assign k = kind_e'(kind);

   always_comb begin
      word = 32'h0;
      case (k)
         K_LW:    word = {OP_LW,   rs, rt, imm};
         K_SW:    word = {OP_SW,   rs, rt, imm};
         K_BEQ:   word = {OP_BEQ,  rs, rt, imm};
         K_BNE:   word = {OP_BNE,  rs, rt, imm};
         K_XORI:  word = {OP_XORI, rs, rt, imm};
         K_ADDI:  word = {OP_ADDI, rs, rt, imm};
         K_J:     word = {OP_J,    jaddr};
         K_JAL:   word = {OP_JAL,  jaddr};
         K_ADD:   word = {OP_RTYPE, rs, rt, rd, 5'h00, FN_ADD};
         K_SUB:   word = {OP_RTYPE, rs, rt, rd, 5'h00, FN_SUB};
         K_SLT:   word = {OP_RTYPE, rs, rt, rd, 5'h00, FN_SLT};
         // JR carries only rs; every other field is forced to zero
         K_JR:    word = {OP_RTYPE, rs, 15'h0, FN_JR};
         default: word = 32'h0;
      endcase
   end

endmodule

// File: rtl/instr_encoder.sv
// Instruction encoder with a word-address counter; one output word one cycle after acceptance.
// Output holds under out_ready=0; with ENC_PSEUDO_EN, BLT/BGE expand to two words and stall requests between them.
module instr_encoder
   import mips_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              addr_clr,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [3:0]        req_kind,
   input  logic [4:0]        req_rs,
   input  logic [4:0]        req_rt,
   input  logic [4:0]        req_rd,
   input  logic [15:0]       req_imm,
   input  logic [25:0]       req_jaddr,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_instr,
   output logic [ADDR_W-1:0] out_addr,
   output logic              err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_EMIT  = 2'd1
`ifdef ENC_PSEUDO_EN
      , S_EMIT2 = 2'd2
`endif
   } state_e;

   state_e            state_q, state_d;
   logic [31:0]       instr_q, instr_d, word1;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic              err_q, err_d;
   logic              accept, out_hs, kind_legal, pend2;
   logic [3:0]        p1_kind;
   logic [4:0]        p1_rd;

`ifdef ENC_PSEUDO_EN
   logic        pend2_q, pend2_d;
   logic [31:0] word2_q, word2_d, word2;
   logic        req_pseudo;
   logic [3:0]  p2_kind;

   // First word of a pseudo branch is slt into $at; second branches on $at with the offset pulled back by one
   assign req_pseudo = is_pseudo_kind(req_kind);
   assign kind_legal = (req_kind != K_BAD);
   assign p1_kind    = req_pseudo ? K_SLT : req_kind;
   assign p1_rd      = req_pseudo ? AT_REG : req_rd;
   assign p2_kind    = (req_kind == K_BLT) ? K_BNE : K_BEQ;
   assign pend2      = pend2_q;

   instr_pack u_pack2 (
      .kind  (p2_kind),
      .rs    (AT_REG),
      .rt    (5'd0),
      .rd    (5'd0),
      .imm   (req_imm - 16'd1),
      .jaddr (26'd0),
      .word  (word2)
   );
`else
   assign kind_legal = (req_kind != K_BAD) && (req_kind != K_BLT) && (req_kind != K_BGE);
   assign p1_kind    = req_kind;
   assign p1_rd      = req_rd;
   assign pend2      = 1'b0;
`endif

   instr_pack u_pack1 (
      .kind  (p1_kind),
      .rs    (req_rs),
      .rt    (req_rt),
      .rd    (p1_rd),
      .imm   (req_imm),
      .jaddr (req_jaddr),
      .word  (word1)
   );

   assign accept = req_valid && req_ready;
   assign out_hs = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (accept && kind_legal) state_d = S_EMIT;
         end
         S_EMIT: begin
            if (out_hs) begin
               if (accept && kind_legal) state_d = S_EMIT;
               else                      state_d = S_IDLE;
`ifdef ENC_PSEUDO_EN
               if (pend2) state_d = S_EMIT2;
`endif
            end
         end
`ifdef ENC_PSEUDO_EN
         S_EMIT2: begin
            if (out_hs) state_d = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q != S_IDLE);
      req_ready = (state_q == S_IDLE) || ((state_q == S_EMIT) && out_ready && !pend2);
   end

   always_comb begin
      instr_d = instr_q;
      addr_d  = addr_q;
      err_d   = err_q;
      if (accept && kind_legal) instr_d = word1;
`ifdef ENC_PSEUDO_EN
      else if ((state_q == S_EMIT) && out_hs && pend2_q) instr_d = word2_q;
`endif
      if (out_hs) addr_d = addr_q + 1'b1;
      if (accept && !kind_legal) err_d = 1'b1;
      // Clear wins over a same-cycle handshake or illegal request
      if (addr_clr) begin
         addr_d = '0;
         err_d  = 1'b0;
      end
   end

`ifdef ENC_PSEUDO_EN
   always_comb begin
      pend2_d = pend2_q;
      word2_d = word2_q;
      if (accept && kind_legal) begin
         pend2_d = req_pseudo;
         word2_d = word2;
      end else if (out_hs) begin
         pend2_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pend2_q <= 1'b0;
         word2_q <= 32'h0;
      end else begin
         pend2_q <= pend2_d;
         word2_q <= word2_d;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         instr_q <= 32'h0;
         addr_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         instr_q <= instr_d;
         addr_q  <= addr_d;
         err_q   <= err_d;
      end
   end

   assign out_instr = instr_q;
   assign out_addr  = addr_q;
   assign err       = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: table vectors, directed corner sequences and a random phase,
// all checked against a word-queue reference model.
module tb_instr_encoder;
   import mips_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1, addr_clr = 1'b0, req_valid = 1'b0, out_ready = 1'b0;
   logic        req_ready, out_valid, err;
   logic [3:0]  req_kind = 4'd0;
   logic [4:0]  req_rs = 5'd0, req_rt = 5'd0, req_rd = 5'd0;
   logic [15:0] req_imm = 16'd0;
   logic [25:0] req_jaddr = 26'd0;
   logic [31:0] out_instr;
   logic [9:0]  out_addr;

   int n_checks = 0;
   int n_fail   = 0;
   bit mon_en   = 1'b0;

   always #5 clk = ~clk;

   instr_encoder #(.ADDR_W(10)) dut (
      .clk(clk), .reset(reset), .addr_clr(addr_clr),
      .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
      .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
      .req_imm(req_imm), .req_jaddr(req_jaddr),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_instr(out_instr), .out_addr(out_addr), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] w;
      bit          second;
   } ent_t;

   ent_t q[$];
   int   exp_addr = 0;
   bit   exp_err  = 1'b0;

   function automatic logic [31:0] itype(input longint op, rs, rt, imm);
      return 32'(op * (64'd1 << 26) + rs * (64'd1 << 21) + rt * (64'd1 << 16) + imm);
   endfunction

   function automatic logic [31:0] rtype(input longint rs, rt, rd, fn);
      return 32'(rs * (64'd1 << 21) + rt * (64'd1 << 16) + rd * (64'd1 << 11) + fn);
   endfunction

   // Returns the number of words the request expands to, or -1 if it is illegal
   function automatic int expand(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                                 input logic [15:0] imm, input logic [25:0] ja,
                                 output logic [31:0] w1, output logic [31:0] w2);
      longint im1;
      w1 = 32'h0;
      w2 = 32'h0;
      im1 = (longint'(imm) + 65535) % 65536;
      case (k)
         K_NOP:  return 1;
         K_LW:   begin w1 = itype(35, rs, rt, imm); return 1; end
         K_SW:   begin w1 = itype(43, rs, rt, imm); return 1; end
         K_BEQ:  begin w1 = itype(4,  rs, rt, imm); return 1; end
         K_BNE:  begin w1 = itype(5,  rs, rt, imm); return 1; end
         K_XORI: begin w1 = itype(14, rs, rt, imm); return 1; end
         K_ADDI: begin w1 = itype(8,  rs, rt, imm); return 1; end
         K_J:    begin w1 = 32'(2 * (64'd1 << 26) + longint'(ja)); return 1; end
         K_JAL:  begin w1 = 32'(3 * (64'd1 << 26) + longint'(ja)); return 1; end
         K_ADD:  begin w1 = rtype(rs, rt, rd, 32); return 1; end
         K_SUB:  begin w1 = rtype(rs, rt, rd, 34); return 1; end
         K_SLT:  begin w1 = rtype(rs, rt, rd, 42); return 1; end
         K_JR:   begin w1 = rtype(rs, 0, 0, 8); return 1; end
`ifdef ENC_PSEUDO_EN
         K_BLT:  begin w1 = rtype(rs, rt, 1, 42); w2 = itype(5, 1, 0, im1); return 2; end
         K_BGE:  begin w1 = rtype(rs, rt, 1, 42); w2 = itype(4, 1, 0, im1); return 2; end
`endif
         default: return -1;
      endcase
   endfunction

   always @(negedge clk) begin
      if (mon_en) begin
         logic [31:0] w1, w2;
         int          n;
         bit          m_ready;
         m_ready = (q.size() == 0) || (q.size() == 1 && !q[0].second && out_ready);
         chk("mon_out_valid", out_valid, q.size() != 0);
         chk("mon_req_ready", req_ready, m_ready);
         chk("mon_err", err, exp_err);
         chk("mon_out_addr", out_addr, exp_addr);
         if (q.size() != 0) chk("mon_out_instr", out_instr, q[0].w);
         if (reset) begin
            q.delete();
            exp_addr = 0;
            exp_err  = 1'b0;
         end else begin
            if (out_valid && out_ready && q.size() != 0) begin
               void'(q.pop_front());
               exp_addr = (exp_addr + 1) % 1024;
            end
            if (req_valid && req_ready) begin
               n = expand(req_kind, req_rs, req_rt, req_rd, req_imm, req_jaddr, w1, w2);
               if (n < 0) exp_err = 1'b1;
               if (n >= 1) q.push_back('{w: w1, second: 1'b0});
               if (n == 2) q.push_back('{w: w2, second: 1'b1});
            end
            if (addr_clr) begin
               exp_addr = 0;
               exp_err  = 1'b0;
            end
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send(input logic [3:0] k, input logic [4:0] rs, rt, rd,
                       input logic [15:0] imm, input logic [25:0] ja);
      bit ok = 1'b0;
      req_kind = k; req_rs = rs; req_rt = rt; req_rd = rd; req_imm = imm; req_jaddr = ja;
      req_valid = 1'b1;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = req_ready;
         @(posedge clk);
         #1;
      end
      req_valid = 1'b0;
      chk("send_accepted", {31'b0, ok}, 32'd1);
   endtask

   task automatic wait_valid(input string name);
      bit ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         @(negedge clk);
         ok = out_valid;
      end
      chk(name, {31'b0, ok}, 32'd1);
   endtask

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_clr;
      addr_clr = 1'b1;
      step();
      addr_clr = 1'b0;
   endtask

   typedef struct {
      logic [3:0]  k;
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [25:0] ja;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[10];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{K_LW,   5'd1,  5'd2, 5'd0, 16'h0010, 26'd0, 32'h8C220010};
      vecs[1] = '{K_SW,   5'd1,  5'd2, 5'd0, 16'h0010, 26'd0, 32'hAC220010};
      vecs[2] = '{K_SUB,  5'd1,  5'd2, 5'd3, 16'h0000, 26'd0, 32'h00221822};
      vecs[3] = '{K_JR,   5'd31, 5'd7, 5'd9, 16'h1234, 26'h3FF, 32'h03E00008};
      vecs[4] = '{K_NOP,  5'd5,  5'd6, 5'd7, 16'hFFFF, 26'h1, 32'h00000000};
      vecs[5] = '{K_BEQ,  5'd1,  5'd2, 5'd0, 16'hFFFF, 26'd0, 32'h1022FFFF};
      vecs[6] = '{K_XORI, 5'd3,  5'd4, 5'd0, 16'hABCD, 26'd0, 32'h3864ABCD};
      vecs[7] = '{K_SLT,  5'd5,  5'd6, 5'd7, 16'h0000, 26'd0, 32'h00A6382A};
      vecs[8] = '{K_BNE,  5'd0,  5'd0, 5'd0, 16'h0001, 26'd0, 32'h14000001};
      vecs[9] = '{K_JAL,  5'd0,  5'd0, 5'd0, 16'h0000, 26'h3FFFFFF, 32'h0FFFFFFF};

      // reset state
      repeat (2) @(posedge clk);
      #1;
      mon_en = 1'b1;
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_instr", out_instr, 0);
      chk("rst_out_addr", out_addr, 0);
      chk("rst_err", err, 0);
      step();
      reset = 1'b0;
      out_ready = 1'b1;

      // ADD at address 0
      send(K_ADD, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
      wait_valid("add_valid");
      chk("add_instr", out_instr, 32'h00432020);
      chk("add_addr", out_addr, 0);
      step();

      // ADDI held under backpressure for 3 cycles
      out_ready = 1'b0;
      send(K_ADDI, 5'd0, 5'd8, 5'd0, 16'd5, 26'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("addi_hold_valid", out_valid, 1);
         chk("addi_hold_instr", out_instr, 32'h20080005);
         chk("addi_hold_addr", out_addr, 1);
         step();
      end
      out_ready = 1'b1;
      step();
      @(negedge clk);
      chk("addi_done_valid", out_valid, 0);
      chk("addi_done_addr", out_addr, 2);
      step();

      foreach (vecs[i]) begin
         send(vecs[i].k, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm, vecs[i].ja);
         wait_valid("vec_valid");
         chk("vec_instr", out_instr, vecs[i].exp);
         step();
      end

      // illegal kind sets err, emits nothing; addr_clr clears both
      send(K_BAD, 5'd1, 5'd1, 5'd1, 16'd1, 26'd1);
      @(negedge clk);
      chk("bad_no_word", out_valid, 0);
      chk("bad_err", err, 1);
      step();
      pulse_clr();
      @(negedge clk);
      chk("clr_err", err, 0);
      chk("clr_addr", out_addr, 0);
      step();

`ifdef ENC_PSEUDO_EN
      send(K_BLT, 5'd2, 5'd3, 5'd0, 16'd4, 26'd0);
      wait_valid("blt_w1_valid");
      chk("blt_w1_instr", out_instr, 32'h0043082A);
      chk("blt_w1_addr", out_addr, 0);
      chk("blt_w1_ready", req_ready, 0);
      step();
      @(negedge clk);
      chk("blt_w2_valid", out_valid, 1);
      chk("blt_w2_instr", out_instr, 32'h14200003);
      chk("blt_w2_addr", out_addr, 1);
      chk("blt_w2_ready", req_ready, 0);
      step();
`else
      send(K_BLT, 5'd2, 5'd3, 5'd0, 16'd4, 26'd0);
      @(negedge clk);
      chk("blt_illegal_no_word", out_valid, 0);
      chk("blt_illegal_err", err, 1);
      step();
      pulse_clr();
      send(K_BGE, 5'd2, 5'd3, 5'd0, 16'd4, 26'd0);
      @(negedge clk);
      chk("bge_illegal_no_word", out_valid, 0);
      chk("bge_illegal_err", err, 1);
      step();
`endif

      // counter wrap: 1023 words then J at 1023 and JAL at 0
      pulse_clr();
      for (int i = 0; i < 1023; i++) send(K_NOP, 5'd0, 5'd0, 5'd0, 16'd0, 26'd0);
      send(K_J, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
      wait_valid("j_valid");
      chk("j_instr", out_instr, 32'h08000100);
      chk("j_addr", out_addr, 1023);
      step();
      send(K_JAL, 5'd0, 5'd0, 5'd0, 16'd0, 26'h100);
      wait_valid("jal_valid");
      chk("jal_instr", out_instr, 32'h0C000100);
      chk("jal_addr", out_addr, 0);
      step();
      step();

      // reset one cycle after the first word of a pending pair handshakes
`ifdef ENC_PSEUDO_EN
      send(K_BLT, 5'd2, 5'd3, 5'd0, 16'd4, 26'd0);
`else
      send(K_ADD, 5'd2, 5'd3, 5'd4, 16'd0, 26'd0);
`endif
      step();
      out_ready = 1'b0;
      reset = 1'b1;
      step();
      reset = 1'b0;
      @(negedge clk);
      chk("midrst_valid", out_valid, 0);
      chk("midrst_addr", out_addr, 0);
      chk("midrst_instr", out_instr, 0);
      step();
      out_ready = 1'b1;
      @(negedge clk);
      chk("midrst_no_second", out_valid, 0);
      step();

      // random phase: the monitor checks every cycle
      for (int c = 0; c < 3000; c++) begin
         bit acc;
         @(negedge clk);
         acc = req_valid && req_ready;
         @(posedge clk);
         #1;
         if (!req_valid || acc) begin
            req_valid = ($urandom_range(0, 2) != 0);
            req_kind  = 4'($urandom_range(0, 15));
            req_rs    = 5'($urandom);
            req_rt    = 5'($urandom);
            req_rd    = 5'($urandom);
            req_imm   = 16'($urandom);
            req_jaddr = 26'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         addr_clr  = ($urandom_range(0, 39) == 0);
      end
      step();
      req_valid = 1'b0;
      addr_clr  = 1'b0;
      out_ready = 1'b1;
      begin
         bit drained = 1'b0;
         for (int i = 0; i < 20 && !drained; i++) begin
            @(negedge clk);
            drained = !out_valid;
         end
         chk("drain", {31'b0, drained}, 32'd1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
